// File: rtl/ccff_chain_bank.sv
// Configuration-chain bank: NUM_CHAINS serial chains loaded in lockstep through a
// valid/ready handshake, committed atomically into a shadow register once a frame is complete.
module ccff_chain_bank #(
  parameter  int CHAIN_LEN  = 16,
  parameter  int NUM_CHAINS = 4,
  localparam int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [NUM_CHAINS-1:0]            din,
  input  logic                             din_valid,
  output logic                             din_ready,
  output logic [NUM_CHAINS-1:0]            tail,
  output logic [NUM_CHAINS*CHAIN_LEN-1:0]  cfg_out,
  output logic                             busy,
  output logic                             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [CHAIN_LEN-1:0]   sreg [NUM_CHAINS];

  // Chain-out taps straight from the flops, so tail moves only on shift cycles.
  always_comb begin
    tail = '0;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      tail[c] = sreg[c][CHAIN_LEN-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      din_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_out   <= '0;
      // NOTE: the shift array is small and the fabric must see a known pattern after reset,
      // so it is reset explicitly instead of being left to power-up contents.
      for (int c = 0; c < NUM_CHAINS; c++) begin
        sreg[c] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            state     <= SHIFT;
            cnt       <= '0;
            din_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end

        SHIFT: begin
          // Abort wins over a slice offered in the same cycle; the partial contents stay put.
          if (abort) begin
            state     <= IDLE;
            din_ready <= 1'b0;
            busy      <= 1'b0;
          end else if (din_valid) begin
            for (int c = 0; c < NUM_CHAINS; c++) begin
              sreg[c] <= {sreg[c][CHAIN_LEN-2:0], din[c]};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(CHAIN_LEN - 1)) begin
              state     <= COMMIT;
              din_ready <= 1'b0;
            end
          end
        end

        COMMIT: begin
          for (int c = 0; c < NUM_CHAINS; c++) begin
            cfg_out[c*CHAIN_LEN +: CHAIN_LEN] <= sreg[c];
          end
          state <= DONE;
          done  <= 1'b1;
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          din_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_bank.sv
// Randomised bench for ccff_chain_bank: frames are modelled as per-chain bit queues, expected
// commits go into a scoreboard queue and a forked monitor compares them whenever done pulses.
module tb_ccff_chain_bank;

  localparam int CL = 16;
  localparam int NC = 4;
  localparam int W  = NC * CL;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [NC-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [NC-1:0] tail;
  logic [W-1:0]  cfg_out;
  logic          busy;
  logic          done;

  ccff_chain_bank #(.CHAIN_LEN(CL), .NUM_CHAINS(NC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .tail      (tail),
    .cfg_out   (cfg_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each chain is a 16-entry bit queue, oldest (deepest) bit at index 0.
  bit             chain_q [NC][$];
  logic [W-1:0]   model_cfg;
  logic [W-1:0]   exp_q [$];
  logic [CL-1:0]  frame [NC];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      chain_q[c] = {};
      for (int i = 0; i < CL; i++) chain_q[c].push_back(1'b0);
    end
    model_cfg = '0;
  endtask

  task automatic model_shift(input logic [NC-1:0] slice);
    for (int c = 0; c < NC; c++) begin
      chain_q[c].push_back(slice[c]);
      void'(chain_q[c].pop_front());
    end
  endtask

  function automatic logic [W-1:0] model_tail();
    logic [W-1:0] t = '0;
    for (int c = 0; c < NC; c++) t[c] = chain_q[c][0];
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic after_reset_checks(input string tag);
    check({tag, "_cfg"}, cfg_out, '0);
    check({tag, "_tail"}, W'(tail), '0);
    check({tag, "_busy"}, W'(busy), '0);
    check({tag, "_done"}, W'(done), '0);
    check({tag, "_ready"}, W'(din_ready), '0);
  endtask

  // mode 0: complete frame; 1: abort when k slices accepted; 2: reset when k slices accepted;
  // 3: reset during the commit cycle.
  task automatic run_frame(input int mode, input int k, input bit gaps);
    int acc;
    logic [W-1:0] exp_cfg;
    logic [NC-1:0] slice;
    for (int c = 0; c < NC; c++) exp_cfg[c*CL +: CL] = frame[c];

    start = 1'b1;
    abort = 1'b0;
    tick();
    start = 1'b0;
    check("ready_after_start", W'(din_ready), W'(1));
    check("busy_after_start", W'(busy), W'(1));

    acc = 0;
    while (acc < CL) begin
      for (int c = 0; c < NC; c++) slice[c] = frame[c][CL-1-acc];
      if (mode == 1 && acc == k) begin
        din = slice;
        din_valid = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        din_valid = 1'b0;
        check("abort_busy", W'(busy), '0);
        check("abort_ready", W'(din_ready), '0);
        check("abort_tail", W'(tail), model_tail());
        check("abort_cfg", cfg_out, model_cfg);
        return;
      end
      if (mode == 2 && acc == k) begin
        din = slice;
        din_valid = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        din_valid = 1'b0;
        model_reset();
        after_reset_checks("rst_shift");
        return;
      end
      din = slice;
      din_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      start = ($urandom_range(0, 5) == 0);
      check("ready_in_shift", W'(din_ready), W'(1));
      tick();
      start = 1'b0;
      if (din_valid) begin
        model_shift(slice);
        acc++;
        check("tail_after_shift", W'(tail), model_tail());
      end
    end
    din_valid = 1'b0;

    check("ready_in_commit", W'(din_ready), '0);
    check("busy_in_commit", W'(busy), W'(1));
    if (mode == 3) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      after_reset_checks("rst_commit");
      return;
    end

    exp_q.push_back(exp_cfg);
    model_cfg = exp_cfg;
    // A slice offered during COMMIT must be refused and leave the chains untouched.
    din = NC'($urandom);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("done_latency", W'(done), W'(1));
    check("tail_hold_commit", W'(tail), model_tail());
    tick();
    check("done_one_cycle", W'(done), '0);
    check("busy_after_done", W'(busy), '0);
  endtask

  task automatic random_frame();
    for (int c = 0; c < NC; c++) frame[c] = CL'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    din = '0;
    din_valid = 1'b0;
    model_reset();

    fork
      forever begin
        @(negedge clk);
        if (!reset && done === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no commit at %0t", $time);
          end else begin
            check("commit_cfg", cfg_out, exp_q.pop_front());
          end
        end
      end
    join_none

    idle(3);
    reset = 1'b0;
    after_reset_checks("reset");

    // Directed frame, back-to-back slices.
    frame[0] = 16'hA5C3; frame[1] = 16'h0001; frame[2] = 16'hFFFF; frame[3] = 16'h8000;
    run_frame(0, 0, 1'b0);
    check("frame_cfg", cfg_out, {16'h8000, 16'hFFFF, 16'h0001, 16'hA5C3});
    idle(2);

    // Same frame with random wait states.
    run_frame(0, 0, 1'b1);
    check("gap_frame_cfg", cfg_out, {16'h8000, 16'hFFFF, 16'h0001, 16'hA5C3});
    idle(1);

    // Abort after seven slices of a new frame; the previous commit stays.
    random_frame();
    frame[0] = 16'hA5C3;
    run_frame(1, 7, 1'b1);
    idle(3);
    check("cfg_kept_after_abort", cfg_out, {16'h8000, 16'hFFFF, 16'h0001, 16'hA5C3});

    random_frame();
    frame[0] = 16'h1234;
    run_frame(0, 0, 1'b1);
    check("post_abort_cfg_chain0", W'(cfg_out[CL-1:0]), W'(16'h1234));
    idle(1);

    // start with abort in IDLE must not begin a frame.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", W'(busy), '0);
    check("start_abort_ready", W'(din_ready), '0);
    idle(2);

    // Reset during the tenth slice, then during COMMIT.
    random_frame();
    run_frame(2, 9, 1'b1);
    idle(2);
    random_frame();
    run_frame(0, 0, 1'b1);
    idle(1);
    random_frame();
    run_frame(3, 0, 1'b0);
    idle(3);

    for (int n = 0; n < 6; n++) begin
      random_frame();
      if (n == 3) begin
        run_frame(1, int'($urandom_range(0, CL - 1)), 1'b1);
      end else begin
        run_frame(0, 0, 1'b1);
      end
      idle(int'($urandom_range(0, 2)));
    end
    check("final_cfg", cfg_out, model_cfg);

    idle(4);
    check("pending_commits", W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
